dcache_dm: RTL and testbench
============================

Name: dcache_dm

Overview:
- Parametrised direct-mapped, write-through, read-allocate data cache.
- Sits between the core's load/store port (ALU address, store data, MEMsrc path) and a slower backing data memory reached through a req/ack handshake.
- Replaces the single-cycle data_mem. Hits cost no stall; a miss or any store stalls the pipeline through `stall` until backing memory completes.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word and line width; one word per line.
- SETS, 16, number of lines; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cpu_re  in  1  load request.
- cpu_we  in  1  store request.
- cpu_addr  in  ADDRESS_WIDTH  byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data.
- stall  out  1  core must hold its request and the PC while high.
- inv_all  in  1  invalidate all lines.
- mem_req  out  1  backing memory request.
- mem_we  out  1  backing memory write.
- mem_addr  out  ADDRESS_WIDTH  word-aligned backing address.
- mem_wdata  out  DATA_WIDTH  backing write data.
- mem_ack  in  1  backing memory completion, sampled on the rising edge of clk.
- mem_rdata  in  DATA_WIDTH  backing read data, valid when mem_ack=1.

Behaviour:
- Address split (IB = log2(SETS)):
  - index = cpu_addr[2+IB-1:2]
  - tag = cpu_addr[ADDRESS_WIDTH-1:2+IB]
  - hit = valid[index] && tag match.
- Reset values: all valid bits 0, state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0. Reset asserted mid-transaction aborts immediately; mem_req falls asynchronously.
- States: IDLE, RD_MISS, WR_THRU, DONE.
- IDLE:
  - cpu_we=1 (takes priority over cpu_re): stall=1; latch address and data; go to WR_THRU.
  - cpu_re=1 on a hit: cpu_rdata comes combinationally from the line, stall=0, no state change.
  - cpu_re=1 on a miss: stall=1; latch the address; go to RD_MISS.
  - No request: stall=0.
- RD_MISS: mem_req=1, mem_we=0, mem_addr held stable. On mem_ack, write the line (valid=1, tag, mem_rdata), capture mem_rdata into the response register, go to DONE.
- WR_THRU: mem_req=1, mem_we=1, addr and data held stable. On mem_ack: if the line hits, update its data (no allocate on a miss); go to DONE.
- DONE (one cycle): stall=0; cpu_rdata = response register; no lookup, no new request accepted. Next state IDLE.
- Stall rule: stall is high in IDLE-with-pending-miss-or-store, RD_MISS and WR_THRU; low in DONE. The core advances on the DONE edge.
- Miss/store latency: 2 + N cycles of stall, where N is the number of wait cycles before mem_ack (ack in the first req cycle gives N=0).
- mem_ack while mem_req=0 is ignored.
- The core holds cpu_* stable while stall=1.
- inv_all:
  - Clears every valid bit in one edge when sampled in IDLE or DONE.
  - While in RD_MISS it is deferred: applied on the ack edge, which leaves the refilled line invalid.
  - Same-cycle inv_all with an IDLE hit: the hit data is still returned that cycle.

Optional Feature:
- Macro: DCACHE_DM_PERF_EN.
- With the macro defined: adds outputs hit_count and miss_count, 32 bits each, reset to 0, saturating at all-ones.
  - hit_count increments once per IDLE read hit.
  - miss_count increments once per IDLE read miss.
  - Stores are not counted.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE, RD_MISS, WR_THRU, DONE)
  - functions idx_bits(SETS) and tag_bits(ADDRESS_WIDTH, SETS)
- Sub-module dcache_line_array holds the valid, tag and data arrays.
  - Ports: async clear, single write port, inv_all.
  - Combinational read by index.
- Top holds the FSM, the latches and the response register.

Test Plan:
All cases use SETS=16.
1. Read miss then hit.
   - Stimulus: reset, then read 0x40; mem returns 0xDEADBEEF with ack 2 cycles after mem_req rises.
   - Response: stall high 4 cycles; DONE shows cpu_rdata=0xDEADBEEF; a re-read of 0x40 gives stall=0 the same cycle and no mem_req.
2. Conflict eviction.
   - Stimulus: read 0x40, then read 0x80 (same index 0, tag 2), then read 0x40.
   - Response: the third access misses and mem_addr=0x40.
3. Write hit.
   - Stimulus: after case 1, store 0x12345678 to 0x40 with zero-wait ack.
   - Response: mem_req=1, mem_we=1, mem_addr=0x40, mem_wdata=0x12345678; stall 2 cycles; a subsequent read of 0x40 hits returning 0x12345678.
4. Write miss, no allocate.
   - Stimulus: store 0x0000CAFE to 0x100, then read 0x100.
   - Response: the read misses and issues mem_req with mem_we=0.
5. Invalidate.
   - Stimulus: after case 1, pulse inv_all in IDLE, then read 0x40.
   - Response: miss, mem_req=1.
6. Reset mid-refill.
   - Stimulus: assert rst during RD_MISS with cpu_re=0.
   - Response: mem_req=0 before the next edge; state IDLE; a later read of 0x40 misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared FSM encoding and address-split helpers for dcache_dm
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int address_width, input int sets);
    return address_width - 2 - $clog2(sets);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// rtl/dcache_line_array.sv - valid/tag/data storage for dcache_dm, comb read, one write port
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int TAG_W  = 26,
  parameter int DATA_W = 32,
  localparam int IB    = idx_bits(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [IB-1:0]     widx_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IB-1:0]     ridx_i,
  output logic              rvalid_o,
  output logic [TAG_W-1:0]  rtag_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];

  // Clear wins over a same-edge write so a deferred invalidate also kills the refilled line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-through read-allocate data cache; DCACHE_DM_PERF_EN adds hit/miss counters
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SETS          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     stall,
  input  logic                     inv_all,
`ifdef DCACHE_DM_PERF_EN
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count,
`endif
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam int IB = idx_bits(SETS);
  localparam int TW = tag_bits(ADDRESS_WIDTH, SETS);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_RD_MISS = RD_MISS;
  localparam logic [1:0] S_WR_THRU = WR_THRU;
  localparam logic [1:0] S_DONE    = DONE;

  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    resp_q, resp_d;
  logic                     inv_pend_q, inv_pend_d;

  logic [ADDRESS_WIDTH-1:0] look_addr;
  logic [IB-1:0]            look_idx;
  logic [TW-1:0]            look_tag;
  logic                     line_valid;
  logic [TW-1:0]            line_tag;
  logic [DATA_WIDTH-1:0]    line_data;
  logic                     hit;
  logic                     arr_we, arr_clr;
  logic [DATA_WIDTH-1:0]    arr_wdata;
  logic                     unused_lo;

  // Once a transaction is latched the core's bus is ignored; lookups use the captured address.
  assign look_addr = (state_q == S_IDLE) ? cpu_addr : addr_q;
  assign look_idx  = look_addr[2+IB-1:2];
  assign look_tag  = look_addr[ADDRESS_WIDTH-1:2+IB];
  assign hit       = line_valid && (line_tag == look_tag);
  assign unused_lo = &{1'b0, look_addr[1:0]};

  dcache_line_array #(
    .SETS   (SETS),
    .TAG_W  (TW),
    .DATA_W (DATA_WIDTH)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (arr_clr),
    .we_i     (arr_we),
    .widx_i   (look_idx),
    .wtag_i   (look_tag),
    .wdata_i  (arr_wdata),
    .ridx_i   (look_idx),
    .rvalid_o (line_valid),
    .rtag_o   (line_tag),
    .rdata_o  (line_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    inv_pend_d = inv_pend_q;
    stall      = 1'b0;
    cpu_rdata  = '0;
    arr_we     = 1'b0;
    arr_clr    = 1'b0;
    arr_wdata  = mem_rdata;
    case (state_q)
      S_IDLE: begin
        arr_clr = inv_all;
        if (cpu_we) begin
          stall      = 1'b1;
          addr_d     = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
          wdata_d    = cpu_wdata;
          inv_pend_d = 1'b0;
          state_d    = S_WR_THRU;
        end else if (cpu_re) begin
          if (hit) begin
            cpu_rdata = line_data;
          end else begin
            stall      = 1'b1;
            addr_d     = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
            inv_pend_d = 1'b0;
            state_d    = S_RD_MISS;
          end
        end
      end
      S_RD_MISS, S_WR_THRU: begin
        stall = 1'b1;
        // An invalidate seen while memory is busy is held and applied on the ack edge.
        if (inv_all) inv_pend_d = 1'b1;
        if (mem_ack) begin
          if (state_q == S_RD_MISS) begin
            arr_we = 1'b1;
            resp_d = mem_rdata;
          end else begin
            arr_we    = hit;
            arr_wdata = wdata_q;
          end
          arr_clr    = inv_pend_q || inv_all;
          inv_pend_d = 1'b0;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        cpu_rdata = resp_q;
        arr_clr   = inv_all;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  assign mem_req   = (state_q == S_RD_MISS) || (state_q == S_WR_THRU);
  assign mem_we    = (state_q == S_WR_THRU);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef DCACHE_DM_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        rd_lookup;

  assign rd_lookup = (state_q == S_IDLE) && cpu_re && !cpu_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rd_lookup && hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (rd_lookup && !hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - scoreboard bench for dcache_dm against a word-level memory/cache model
module tb_dcache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we, inv_all, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_DM_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_dm #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SETS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .inv_all   (inv_all),
`ifdef DCACHE_DM_PERF_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mop_t;

  int          n_vec = 0;
  int          n_bad = 0;
  mop_t        mop_q[$];
  logic [31:0] load_q[$];
  logic [31:0] bmem[logic [31:0]];
  bit          ref_valid[16];
  logic [25:0] ref_tag[16];
  int          ack_delay = 0;
  int          ref_hits = 0;
  int          ref_misses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic ref_clear();
    foreach (ref_valid[i]) ref_valid[i] = 1'b0;
  endtask

  // Load-response monitor: a load completes on any cycle with a read held and no stall.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && cpu_re && !cpu_we && !stall) begin
        if (load_q.size() == 0) fail_now("unexpected_load_response");
        else chk("cpu_rdata", cpu_rdata, load_q.pop_front());
      end
    end
  end

  // Backing memory: checks each request, acks after ack_delay waits, injects stray acks while idle.
  initial begin
    mop_t e;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (mop_q.size() == 0) begin
          fail_now("unexpected_mem_req");
        end else begin
          e = mop_q.pop_front();
          chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
        for (int k = 0; k < ack_delay && mem_req; k++) @(negedge clk);
        if (mem_req) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? $urandom() : mem_val(mem_addr);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom();
      end
    end
  end

  // One core access. inv: same-cycle invalidate on a read hit, mid-refill invalidate on a read miss.
  task automatic do_op(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input int dly, input bit inv);
    logic [31:0] wa;
    logic [25:0] tag;
    int          idx, exp_stall, cnt;
    bit          hit, inv_hit, inv_miss;
    wa        = {addr[31:2], 2'b00};
    idx       = int'(addr[5:2]);
    tag       = addr[31:6];
    hit       = ref_valid[idx] && (ref_tag[idx] == tag);
    inv_hit   = inv && !we && hit;
    inv_miss  = inv && !we && !hit;
    ack_delay = dly;
    if (we) begin
      mop_q.push_back('{1'b1, wa, wd});
      bmem[wa]  = wd;
      exp_stall = 2 + dly;
    end else begin
      load_q.push_back(mem_val(wa));
      if (hit) begin
        exp_stall = 0;
        ref_hits++;
      end else begin
        mop_q.push_back('{1'b0, wa, 32'h0});
        exp_stall = 2 + dly;
        ref_misses++;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
      end
    end
    if (inv_hit || inv_miss) ref_clear();

    @(posedge clk); #1;
    cpu_we    = we;
    cpu_re    = !we || ($urandom_range(0, 1) == 1);
    cpu_addr  = addr;
    cpu_wdata = we ? wd : $urandom();
    inv_all   = inv_hit;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      cnt++;
      inv_all = inv_miss && (cnt == 2);
      if (cnt > 200) begin
        fail_now("stall_timeout");
        break;
      end
    end
    chk("stall_cycles", cnt, exp_stall);
    @(posedge clk); #1;
    inv_all  = 1'b0;
    cpu_re   = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = $urandom();
  endtask

  task automatic inv_pulse();
    inv_all = 1'b1;
    @(posedge clk); #1;
    inv_all = 1'b0;
    ref_clear();
  endtask

  initial begin
    logic [31:0] ra;
    rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; inv_all = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    ref_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    bmem[32'h40] = 32'hDEAD_BEEF;
    do_op(0, 32'h40, 0, 2, 0);
    do_op(0, 32'h40, 0, 0, 0);
    do_op(1, 32'h40, 32'h1234_5678, 0, 0);
    do_op(0, 32'h41, 0, 0, 0);
    inv_pulse();
    do_op(0, 32'h40, 0, 1, 0);
    do_op(0, 32'h80, 0, 0, 0);
    do_op(0, 32'h40, 0, 3, 0);
    do_op(1, 32'h100, 32'h0000_CAFE, 1, 0);
    do_op(0, 32'h100, 0, 0, 0);
    do_op(0, 32'h200, 0, 0, 1);
    do_op(0, 32'h200, 0, 2, 1);
    do_op(0, 32'h200, 0, 0, 0);
    do_op(0, 32'h202, 0, 0, 1);
    do_op(0, 32'h200, 0, 1, 0);

    for (int n = 0; n < 400; n++) begin
      ra = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      do_op($urandom_range(0, 9) < 3, ra, $urandom(), $urandom_range(0, 3),
            $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) inv_pulse();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    do_op(0, 32'h40, 0, 0, 0);
    ack_delay = 50;
    mop_q.push_back('{1'b0, 32'h3C0, 32'h0});
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_addr = 32'h3C0;
    @(posedge clk); #1;
    cpu_re = 1'b0;
    @(negedge clk);
    chk("refill_mem_req", {31'b0, mem_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
    chk("abort_mem_we", {31'b0, mem_we}, 32'd0);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    ref_clear();
    ref_hits = 0;
    ref_misses = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(0, 32'h40, 0, 1, 0);
    do_op(0, 32'h40, 0, 0, 0);

    repeat (2) @(posedge clk);
    chk("mem_ops_outstanding", mop_q.size(), 32'd0);
    chk("loads_outstanding", load_q.size(), 32'd0);
`ifdef DCACHE_DM_PERF_EN
    chk("hit_count", hit_count, ref_hits);
    chk("miss_count", miss_count, ref_misses);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
